// File: rtl/mem_req_master.sv
// Memory-slave requester: command FIFO feeding a one-at-a-time IDLE/REQ/GAP bus FSM.
// Optional MEM_REQ_TIMEOUT_EN aborts a request after TIMEOUT cycles without ready.
module mem_req_master #(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_wr_rd,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [WIDTH-1:0]      cmd_wdata,
  output logic                  wr_rd,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [WIDTH-1:0]      wdata,
  output logic                  valid,
  input  logic [WIDTH-1:0]      rdata,
  input  logic                  ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy
);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;
  localparam int ENT = 1 + ADDR_WIDTH + WIDTH;

  typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;
  state_t state, nxt;

  logic [FIFO_DEPTH-1:0][ENT-1:0] fifo_q;
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic          full, empty, push, pop, done, to_hit;
  logic [ENT-1:0] head;

  assign full      = (count == CW'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign cmd_ready = ~full;
  assign push      = cmd_valid & ~full;
  assign head      = fifo_q[rptr];
  assign busy      = ~empty | (state != IDLE);

  always_ff @(posedge clk) begin
    if (push) fifo_q[wptr] <= {cmd_wr_rd, cmd_addr, cmd_wdata};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

`ifdef MEM_REQ_TIMEOUT_EN
  localparam int TW = ($clog2(TIMEOUT) > 4) ? $clog2(TIMEOUT) : 4;
  logic [TW-1:0] to_cnt;

  assign to_hit = (state == REQ) && !ready && (to_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                    to_cnt <= '0;
    else if (pop)                                to_cnt <= '0;
    else if (state == REQ && !ready && !to_hit)  to_cnt <= to_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                       rsp_err <= 1'b0;
    else if (done && !wr_rd)        rsp_err <= 1'b0;
    else if (to_hit && !wr_rd)      rsp_err <= 1'b1;
  end
`else
  assign to_hit  = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  // Reads are held back while a response is pending so rsp_rdata never overruns.
  always_comb begin
    nxt  = state;
    pop  = 1'b0;
    done = 1'b0;
    case (state)
      IDLE: if (!empty && (head[ENT-1] || !rsp_valid)) begin
        pop = 1'b1;
        nxt = REQ;
      end
      REQ: begin
        if (ready) begin
          done = 1'b1;
          nxt  = GAP;
        end else if (to_hit) begin
          nxt  = GAP;
        end
      end
      GAP:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      wr_rd <= 1'b0;
      addr  <= '0;
      wdata <= '0;
    end else if (pop) begin
      {wr_rd, addr, wdata} <= head;
      valid                <= 1'b1;
    end else if (done || to_hit) begin
      valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else if (done && !wr_rd) begin
      rsp_valid <= 1'b1;
      rsp_rdata <= rdata;
    end else if (to_hit && !wr_rd) begin
      rsp_valid <= 1'b1;
      rsp_rdata <= '0;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mem_req_master.sv
// Bench for mem_req_master: behavioural memory slave plus a read-response scoreboard.
module tb_mem_req_master;
  localparam int W = 16, D = 32, AW = 5, TO = 15;

  logic clk = 1'b0, rst = 1'b0;
  logic cmd_valid = 1'b0, cmd_ready, cmd_wr_rd = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [W-1:0]  cmd_wdata = '0;
  logic wr_rd, valid, ready, rsp_valid, rsp_ready = 1'b0, rsp_err, busy;
  logic [AW-1:0] addr;
  logic [W-1:0]  wdata, rdata, rsp_rdata;

  mem_req_master #(.WIDTH(W), .DEPTH(D), .ADDR_WIDTH(AW), .FIFO_DEPTH(4), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr_rd(cmd_wr_rd),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .wr_rd(wr_rd), .addr(addr), .wdata(wdata),
    .valid(valid), .rdata(rdata), .ready(ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy));

  always #5 clk = ~clk;

  // Level-handshake slave: executes once when valid rises, drops ready when valid drops.
  logic [W-1:0] smem [D];
  logic [W-1:0] shadow [D];
  logic slave_en = 1'b1;
  initial begin
    for (int i = 0; i < D; i++) begin smem[i] = '0; shadow[i] = '0; end
  end
  always @(posedge clk) begin
    if (!rst || !slave_en) ready <= 1'b0;
    else if (valid && !ready) begin
      if (wr_rd) smem[addr] <= wdata;
      else       rdata <= smem[addr];
      ready <= 1'b1;
    end else ready <= 1'b0;
  end

  typedef struct packed { logic [W-1:0] d; logic e; } exp_t;
  exp_t exp_q [$];
  int vecs = 0, errs = 0;

  task automatic push_cmd(input logic wr, input logic [AW-1:0] a, input logic [W-1:0] d, input logic to);
    int t = 0;
    exp_t x;
    while (!cmd_ready && t < 200) begin @(negedge clk); t++; end
    vecs++;
    if (cmd_ready !== 1'b1) begin errs++; $display("FAIL push_cmd: cmd_ready=%b required 1", cmd_ready); end
    cmd_valid = 1'b1; cmd_wr_rd = wr; cmd_addr = a; cmd_wdata = d;
    if (wr) shadow[a] = d;
    else begin
      x.d = to ? '0 : shadow[a];
      x.e = to;
      exp_q.push_back(x);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(input string nm);
    int t = 0;
    exp_t x;
    while (!rsp_valid && t < 300) begin @(negedge clk); t++; end
    x = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    vecs++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== x.d || rsp_err !== x.e) begin
      errs++;
      $display("FAIL %s: got v=%b d=%h e=%b, required v=1 d=%h e=%b", nm, rsp_valid, rsp_rdata, rsp_err, x.d, x.e);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    vecs++;
    if (rsp_valid !== 1'b0) begin errs++; $display("FAIL %s_clear: rsp_valid=%b required 0", nm, rsp_valid); end
  endtask

  task automatic test_reset();
    logic [W-1:0] save;
    repeat (2) @(negedge clk);
    vecs++;
    if ({valid, busy, cmd_ready, rsp_valid, rsp_err, wr_rd, addr, wdata, rsp_rdata} !== {5'b00100, 1'b0, {AW{1'b0}}, {W{1'b0}}, {W{1'b0}}}) begin
      errs++;
      $display("FAIL reset_state: valid=%b busy=%b cmd_ready=%b rsp_valid=%b rsp_err=%b addr=%h wdata=%h rsp_rdata=%h, required 0 0 1 0 0 0 0 0",
               valid, busy, cmd_ready, rsp_valid, rsp_err, addr, wdata, rsp_rdata);
    end
    rst = 1'b1;
    @(negedge clk);
    slave_en = 1'b0;
    save = shadow[9];
    push_cmd(1'b1, 5'd9, 16'h1234, 1'b0);
    repeat (2) @(negedge clk);
    vecs++;
    if (valid !== 1'b1) begin errs++; $display("FAIL reset_pre_req: valid=%b required 1", valid); end
    #2 rst = 1'b0;
    #1;
    vecs++;
    if (valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      errs++;
      $display("FAIL reset_mid_req: valid=%b busy=%b cmd_ready=%b required 0 0 1", valid, busy, cmd_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    shadow[9] = save;
    slave_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write();
    cmd_valid = 1'b1; cmd_wr_rd = 1'b1; cmd_addr = 5'd3; cmd_wdata = 16'hBEEF;
    shadow[3] = 16'hBEEF;
    @(negedge clk);
    cmd_valid = 1'b0;
    vecs++;
    if (valid !== 1'b0) begin errs++; $display("FAIL wr_latency1: valid=%b required 0", valid); end
    @(negedge clk);
    vecs++;
    if (valid !== 1'b1 || wr_rd !== 1'b1 || addr !== 5'd3 || wdata !== 16'hBEEF) begin
      errs++;
      $display("FAIL wr_issue: valid=%b wr_rd=%b addr=%h wdata=%h required 1 1 03 beef", valid, wr_rd, addr, wdata);
    end
    @(negedge clk);
    vecs++;
    if (valid !== 1'b1 || addr !== 5'd3) begin errs++; $display("FAIL wr_hold: valid=%b addr=%h required 1 03", valid, addr); end
    @(negedge clk);
    vecs++;
    if (valid !== 1'b0 || smem[3] !== 16'hBEEF) begin
      errs++;
      $display("FAIL wr_gap: valid=%b mem3=%h required 0 beef", valid, smem[3]);
    end
    @(negedge clk);
    vecs++;
    if (busy !== 1'b0 || valid !== 1'b0) begin errs++; $display("FAIL wr_idle: busy=%b valid=%b required 0 0", busy, valid); end
  endtask

  task automatic test_read_after_write();
    push_cmd(1'b1, 5'd3, 16'hBEEF, 1'b0);
    push_cmd(1'b0, 5'd3, '0, 1'b0);
    get_rsp("raw_read3");
    push_cmd(1'b1, 5'd31, 16'hA5A5, 1'b0);
    push_cmd(1'b1, 5'd0, 16'h5A5A, 1'b0);
    push_cmd(1'b0, 5'd31, '0, 1'b0);
    push_cmd(1'b0, 5'd0, '0, 1'b0);
    get_rsp("raw_read31");
    get_rsp("raw_read0");
  endtask

  task automatic test_full_fifo();
    logic pv, pr, saw_ready;
    int xfers = 0, t = 0;
    slave_en = 1'b0;
    for (int i = 0; i < 5; i++) push_cmd(1'b1, AW'(10 + i), W'(16'h1000 + i), 1'b0);
    repeat (5) @(negedge clk);
    vecs++;
    if (cmd_ready !== 1'b0 || valid !== 1'b1 || addr !== 5'd10) begin
      errs++;
      $display("FAIL full_stall: cmd_ready=%b valid=%b addr=%h required 0 1 0a", cmd_ready, valid, addr);
    end
    slave_en = 1'b1;
    saw_ready = 1'b0;
    pv = valid; pr = ready;
    while (busy && t < 200) begin
      @(negedge clk);
      t++;
      if (pv && pr) begin
        xfers++;
        vecs++;
        if (valid !== 1'b0) begin errs++; $display("FAIL full_gap: valid=%b after ready, required 0", valid); end
      end
      if (cmd_ready) saw_ready = 1'b1;
      pv = valid; pr = ready;
    end
    vecs++;
    if (xfers !== 5 || saw_ready !== 1'b1 || busy !== 1'b0) begin
      errs++;
      $display("FAIL full_drain: xfers=%0d cmd_ready_seen=%b busy=%b required 5 1 0", xfers, saw_ready, busy);
    end
    for (int i = 0; i < 5; i++) push_cmd(1'b0, AW'(10 + i), '0, 1'b0);
    for (int i = 0; i < 5; i++) get_rsp("full_readback");
  endtask

  task automatic test_backpressure();
    int bad = 0;
    logic [W-1:0] first;
    push_cmd(1'b1, 5'd20, 16'h0F0F, 1'b0);
    push_cmd(1'b0, 5'd3, '0, 1'b0);
    push_cmd(1'b0, 5'd20, '0, 1'b0);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (valid && rsp_valid) bad++;
    end
    first = (exp_q.size() > 0) ? exp_q[0].d : '0;
    vecs++;
    if (bad !== 0 || rsp_valid !== 1'b1 || rsp_rdata !== first || busy !== 1'b1) begin
      errs++;
      $display("FAIL backpressure: issued_while_pending=%0d rsp_valid=%b rdata=%h busy=%b required 0 1 %h 1",
               bad, rsp_valid, rsp_rdata, busy, first);
    end
    get_rsp("bp_first");
    get_rsp("bp_second");
  endtask

  task automatic test_timeout();
    int n = 0;
    slave_en = 1'b0;
`ifdef MEM_REQ_TIMEOUT_EN
    push_cmd(1'b0, 5'd7, '0, 1'b1);
    while (!valid && n < 50) begin @(negedge clk); n++; end
    n = 0;
    while (valid && n < 100) begin @(negedge clk); n++; end
    vecs++;
    if (n !== TO) begin errs++; $display("FAIL timeout_len: valid_cycles=%0d required %0d", n, TO); end
    get_rsp("timeout_rsp");
`else
    push_cmd(1'b0, 5'd7, '0, 1'b0);
    repeat (40) @(negedge clk);
    vecs++;
    if (valid !== 1'b1 || rsp_valid !== 1'b0) begin
      errs++;
      $display("FAIL no_timeout: valid=%b rsp_valid=%b required 1 0", valid, rsp_valid);
    end
    slave_en = 1'b1;
    get_rsp("late_read7");
`endif
    slave_en = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_after_write();
    test_full_fifo();
    test_backpressure();
    test_timeout();
    vecs++;
    if (exp_q.size() !== 0) begin errs++; $display("FAIL scoreboard_left: %0d entries, required 0", exp_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end
endmodule
